// File: rtl/pipe_seg_skid_if.sv
// Valid/allowin handshake bundle carrying one opaque DATA_W-bit payload between stages.
// The master modport drives valid and data; the slave modport drives allowin.
interface pipe_seg_skid_if #(
  parameter int unsigned DATA_W = 128
) ();
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              allowin;

  modport master (output valid, output data, input allowin);
  modport slave  (input valid, input data, output allowin);
endinterface

// File: rtl/pipe_seg_skid.sv
// Parametrised pipeline segment register with a 2-entry skid buffer and a registered allowin.
// Optional perf counters are built only when PIPE_SEG_PERF_EN is defined.
module pipe_seg_skid #(
  parameter int unsigned       DATA_W      = 128,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter bit                ZERO_BUBBLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  pipe_seg_skid_if.slave         in_if,
  pipe_seg_skid_if.master        out_if,
  input  logic                   flush,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_bubble_cnt
);

  // Encoding is {main_v, skid_v}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic              allowin_q, allowin_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              main_v, in_fire, out_fire;

  assign main_v        = state_q[1];
  assign in_fire       = in_if.valid & allowin_q;
  assign out_fire      = main_v & out_if.allowin;

  assign in_if.allowin = allowin_q;
  assign out_if.valid  = main_v;
  assign out_if.data   = main_data_q;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d     = StOne;
            main_data_d = in_if.data;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_data_d = in_if.data;
          end else if (in_fire) begin
            state_d     = StFull;
            skid_data_d = in_if.data;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d     = StOne;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    // Downstream sees RESET_VAL in every bubble, matching the old fixed segments.
    if (ZERO_BUBBLE && main_v && (state_d == StEmpty)) begin
      main_data_d = RESET_VAL;
    end
    allowin_d = (state_d != StFull);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StEmpty;
      allowin_q   <= 1'b1;
      main_data_q <= RESET_VAL;
      skid_data_q <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      allowin_q   <= allowin_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_SEG_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush intentionally leaves them alone.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_v && !out_if.allowin && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!main_v && out_if.allowin && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_stall_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Scoreboard bench for pipe_seg_skid: occupancy/FIFO reference model plus negedge monitor.
// A second instance with ZERO_BUBBLE=0 checks that drained data is held.
module tb_pipe_seg_skid;
  localparam int unsigned W = 32;
`ifdef PIPE_SEG_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  logic h_flush = 1'b0;
  logic [31:0] stall_cnt, bubble_cnt, h_stall_cnt, h_bubble_cnt;

  always #5 clk = ~clk;

  pipe_seg_skid_if #(.DATA_W(W)) in_if ();
  pipe_seg_skid_if #(.DATA_W(W)) out_if ();
  pipe_seg_skid_if #(.DATA_W(W)) h_in_if ();
  pipe_seg_skid_if #(.DATA_W(W)) h_out_if ();

  pipe_seg_skid #(.DATA_W(W), .RESET_VAL(32'h0), .ZERO_BUBBLE(1'b1)) u_dut (
    .clk             (clk),
    .resetn          (resetn),
    .in_if           (in_if),
    .out_if          (out_if),
    .flush           (flush),
    .perf_stall_cnt  (stall_cnt),
    .perf_bubble_cnt (bubble_cnt)
  );

  pipe_seg_skid #(.DATA_W(W), .RESET_VAL(32'h0), .ZERO_BUBBLE(1'b0)) u_hold (
    .clk             (clk),
    .resetn          (resetn),
    .in_if           (h_in_if),
    .out_if          (h_out_if),
    .flush           (h_flush),
    .perf_stall_cnt  (h_stall_cnt),
    .perf_bubble_cnt (h_bubble_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the segment is a 2-deep FIFO; allowin is "fewer than two words held".
  typedef struct {
    int unsigned   seq;
    logic [W-1:0]  data;
  } ent_t;

  ent_t        sb[$];
  int unsigned next_seq = 0;
  int unsigned kill_mark = 0;
  int          occ = 0;
  int unsigned stall_m = 0;
  int unsigned bubble_m = 0;
  logic        m_in_fire, m_out_fire;

  assign m_out_fire = (occ > 0) && out_if.allowin;
  assign m_in_fire  = in_if.valid && (occ < 2);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ       <= 0;
      kill_mark <= next_seq;
      stall_m   <= 0;
      bubble_m  <= 0;
    end else begin
      if ((occ > 0) && !out_if.allowin) stall_m <= stall_m + 1;
      if ((occ == 0) && out_if.allowin) bubble_m <= bubble_m + 1;
      if (m_in_fire) begin
        sb.push_back('{seq: next_seq, data: in_if.data});
        next_seq <= next_seq + 1;
      end
      if (flush) begin
        occ       <= 0;
        kill_mark <= next_seq + (m_in_fire ? 1 : 0);
      end else begin
        occ <= occ - (m_out_fire ? 1 : 0) + (m_in_fire ? 1 : 0);
      end
    end
  end

  // Monitor: drops flushed entries, then compares whatever the DUT presents.
  always @(negedge clk) begin
    if (resetn) begin
      while ((sb.size() > 0) && (sb[0].seq < kill_mark)) void'(sb.pop_front());
      check("out_valid", {31'd0, out_if.valid}, {31'd0, occ > 0});
      check("in_allowin", {31'd0, in_if.allowin}, {31'd0, occ < 2});
      if (out_if.valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_word: got %0h, expected no word (t=%0t)", out_if.data, $time);
        end else begin
          check("out_data", out_if.data, sb[0].data);
          if (out_if.allowin) void'(sb.pop_front());
        end
      end else begin
        check("bubble_data", out_if.data, 32'h0);
      end
      check("perf_stall", stall_cnt, PERF ? stall_m : 32'd0);
      check("perf_bubble", bubble_cnt, PERF ? bubble_m : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic oa, input logic fl);
    in_if.valid    = v;
    in_if.data     = d;
    out_if.allowin = oa;
    flush          = fl;
  endtask

  initial begin
    int live;
    drive(1'b0, '0, 1'b0, 1'b0);
    h_in_if.valid    = 1'b0;
    h_in_if.data     = '0;
    h_out_if.allowin = 1'b1;
    #12;
    resetn = 1'b1;

    // Streaming: 1-cycle latency, full throughput.
    drive(1'b1, 32'h11, 1'b1, 1'b0); step();
    check("stream0", out_if.data, 32'h11);
    drive(1'b1, 32'h22, 1'b1, 1'b0); step();
    check("stream1", out_if.data, 32'h22);
    drive(1'b1, 32'h33, 1'b1, 1'b0); step();
    check("stream2", out_if.data, 32'h33);
    drive(1'b0, '0, 1'b1, 1'b0); step(); step();

    // Backpressure: A, B fill the segment, C waits for allowin.
    drive(1'b1, 32'hA, 1'b0, 1'b0); step();
    drive(1'b1, 32'hB, 1'b0, 1'b0); step();
    check("full_allowin", {31'd0, in_if.allowin}, 32'd0);
    drive(1'b1, 32'hC, 1'b0, 1'b0); step();
    check("full_hold", out_if.data, 32'hA);
    drive(1'b1, 32'hC, 1'b1, 1'b0); step();
    check("drain_b", out_if.data, 32'hB);
    step();
    drive(1'b0, '0, 1'b1, 1'b0); step(); step();

    // Flush in FULL with in_valid high.
    drive(1'b1, 32'hD, 1'b0, 1'b0); step();
    drive(1'b1, 32'hE, 1'b0, 1'b0); step();
    drive(1'b1, 32'hF, 1'b0, 1'b1); step();
    check("flush_valid", {31'd0, out_if.valid}, 32'd0);
    check("flush_allowin", {31'd0, in_if.allowin}, 32'd1);
    check("flush_zero", out_if.data, 32'h0);
    // Flush in ONE while a word is accepted: that word is discarded.
    drive(1'b1, 32'h61, 1'b0, 1'b0); step();
    drive(1'b1, 32'h62, 1'b0, 1'b1); step();
    check("flush_in_fire", {31'd0, out_if.valid}, 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0); step();

    // Asynchronous reset mid-cycle with a word held.
    drive(1'b1, 32'h99, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b1, 1'b0);
    resetn = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_if.valid}, 32'd0);
    check("rst_data", out_if.data, 32'h0);
    check("rst_allowin", {31'd0, in_if.allowin}, 32'd1);
    check("rst_stall", stall_cnt, 32'd0);
    step();
    resetn = 1'b1;

    // Perf: 3 bubble cycles, then 5 stall cycles, then flush.
    step(); step(); step();
    drive(1'b1, 32'h77, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    drive(1'b0, '0, 1'b1, 1'b1); step();
    check("perf_stall5", stall_cnt, PERF ? 32'd5 : 32'd0);
    check("perf_bubble3", bubble_cnt, PERF ? 32'd3 : 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0); step();
    check("perf_stall_kept", stall_cnt, PERF ? 32'd5 : 32'd0);
    check("perf_bubble_kept", bubble_cnt, PERF ? 32'd3 : 32'd0);

    // ZERO_BUBBLE=0: drained word stays on the data bus.
    h_in_if.valid = 1'b1;
    h_in_if.data  = 32'h55;
    step();
    check("hold_valid1", {31'd0, h_out_if.valid}, 32'd1);
    check("hold_data1", h_out_if.data, 32'h55);
    h_in_if.valid = 1'b0;
    step();
    check("hold_valid0", {31'd0, h_out_if.valid}, 32'd0);
    check("hold_data0", h_out_if.data, 32'h55);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 40) == 0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    #1;
    live = 0;
    foreach (sb[i]) if (sb[i].seq >= kill_mark) live++;
    check("leftover", live, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_seg_skid.md
Name: pipe_seg_skid

Overview:
- Parametrised successor to the fixed per-stage pipeline segment registers (IF/ID, ID/EX, EX/MEM, …).
- Carries one packed payload bus of DATA_W bits between two pipeline stages using a valid/allowin handshake.
- A 2-entry skid buffer keeps upstream allowin registered, so no combinational ready path crosses the stage.
- Supports flush (exception/branch kill) and optional zeroing of bubbles.

Parameters:
- DATA_W, 128, payload width in bits (pc, inst, operands and control fields packed by the instantiating stage).
- RESET_VAL, {DATA_W{1'b0}}, value loaded into both data registers at reset.
- ZERO_BUBBLE, 1, 1: main data register is reloaded with RESET_VAL whenever it becomes invalid; 0: data holds its last value.

Ports:
- clk  in  1  clock; all state on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream has a word.
- in_data  in  DATA_W  upstream payload.
- in_allowin  out  1  segment accepts a word this cycle; registered.
- out_valid  out  1  main register holds a valid word.
- out_data  out  DATA_W  main register payload.
- out_allowin  in  1  downstream accepts this cycle.
- flush  in  1  kill all contents this cycle.
- perf_stall_cnt  out  32  stall cycle counter (see Optional Feature).
- perf_bubble_cnt  out  32  bubble cycle counter (see Optional Feature).

Behaviour:
- Storage:
  - main register: main_v, main_d; drives out_valid and out_data.
  - skid register: skid_v, skid_d.
- Handshake:
  - in_fire = in_valid & in_allowin.
  - out_fire = out_valid & out_allowin.
  - in_allowin = !skid_v, taken directly from a flop.
- States, encoded by {main_v, skid_v}: EMPTY=00, ONE=10, FULL=11. The encoding 01 is unreachable.
- EMPTY:
  - in_fire -> ONE, main_d<=in_data.
  - else stay EMPTY.
- ONE:
  - in_fire & out_fire -> ONE, main_d<=in_data.
  - in_fire & !out_fire -> FULL, skid_d<=in_data.
  - !in_fire & out_fire -> EMPTY.
  - neither -> ONE, hold.
- FULL:
  - in_allowin=0.
  - out_fire -> ONE, main_d<=skid_d, skid cleared.
  - else hold.
- Ordering: strict FIFO. No word is duplicated, reordered or dropped except by flush.
- Flush:
  - Next state is EMPTY regardless of in_fire/out_fire.
  - A word presented with in_fire in the flush cycle is discarded.
  - A word leaving with out_fire in the flush cycle still counts as delivered downstream.
  - The cycle after flush: in_allowin=1.
- ZERO_BUBBLE=1: on any transition into main_v=0 (drain or flush), main_d<=RESET_VAL. Downstream therefore sees a zero bubble, as the fixed segments give.
- Reset (async assert, sync release):
  - main_v=0, skid_v=0, main_d=skid_d=RESET_VAL.
  - out_valid=0, out_data=RESET_VAL, in_allowin=1.
  - Counters=0.
  - Reset asserted mid-transfer discards all contents immediately, without waiting for a clock edge.
- Latency:
  - 1 cycle from in_fire to out_valid when the segment is EMPTY.
  - Throughput 1 word/cycle while out_allowin=1.
- Payload bits are opaque. Width is set only by DATA_W; no arithmetic is performed on them.

Optional Feature:
- Macro: PIPE_SEG_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle with out_valid & !out_allowin.
  - perf_bubble_cnt increments each cycle with !out_valid & out_allowin.
  - Both saturate at 32'hFFFF_FFFF.
  - Both are cleared only by reset; flush does not clear them.
- Not defined: counter flops are not built, and both ports are tied to 32'h0.

Test Plan:
- Reset, then streaming with DATA_W=32:
  - Stimulus: resetn low mid-cycle; check out_valid=0, out_data=0, in_allowin=1 before the next clk. Then stream 0x11,0x22,0x33 on consecutive cycles with out_allowin=1.
  - Required response: out_data shows 0x11,0x22,0x33 on cycles 1..3 with out_valid=1, and in_allowin stays 1.
- Backpressure:
  - Stimulus: out_allowin=0; send 0xA then 0xB.
  - Required response: state FULL, in_allowin=0 the next cycle, 0xC is held off. After out_allowin=1, the bench sees 0xA, 0xB, 0xC in order with no loss.
- Flush in FULL with a simultaneous in_valid:
  - Required response: next cycle out_valid=0, in_allowin=1. With ZERO_BUBBLE=1, out_data=0. The flushed input word never appears at the output.
- Drain with ZERO_BUBBLE=0:
  - Stimulus: word 0x55 passes through, then in_valid=0.
  - Required response: out_valid=0, out_data holds 0x55.
- PIPE_SEG_PERF_EN defined:
  - Stimulus: 5 cycles with out_valid=1 & out_allowin=0, and 3 cycles empty with out_allowin=1.
  - Required response: perf_stall_cnt=5, perf_bubble_cnt=3. A subsequent flush leaves both counts unchanged.
  - Without the macro, both counters read 0.
